imm_lut_ctrl: RTL and testbench
===============================

// Module: imm_lut_ctrl
// PURPOSE
// - Writable, sequenced replacement for the fixed immediate lookup table in the register-write path.
// - Owns a 2**ADDR_W x DATA_W table and reloads it with the default immediates after every reset.
// - Serves decode-stage immediate reads with one cycle of latency.
// - Accepts table rewrites from a config/test requester through a valid/ready handshake.
// PARAMETERS
// - DATA_W  8  width of each table entry and of datOut
// - ADDR_W  4  table index width; the table has 2**ADDR_W entries, and rd_in is ADDR_W+1 bits wide
// PORTS
// - Clk      in   1         single clock; all state updates on the rising edge
// - Reset    in   1         synchronous, active-high
// - rd_en    in   1         read request from decode; sampled on the clock edge
// - rd_in    in   ADDR_W+1  [ADDR_W]=1 selects table[rd_in[ADDR_W-1:0]]; [ADDR_W]=0 selects the direct immediate
// - rd_valid out  1         pulses high for 1 cycle when datOut carries a new result
// - datOut   out  DATA_W    registered read result
// - wr_valid in   1         config write request
// - wr_ready out  1         controller can accept a write this cycle
// - wr_addr  in   ADDR_W    entry to overwrite
// - wr_data  in   DATA_W    new entry value
// - busy     out  1         high while the table is initialising
// BEHAVIOUR
// - States: INIT, RUN, and LOCKED (LOCKED exists only with the macro).
// - Reset, including mid-operation:
//   - State goes to INIT and init index idx goes to 0.
//   - datOut=0, rd_valid=0, wr_ready=0, busy=1.
//   - Any in-flight read result or write is discarded; the table is fully reloaded.
// - INIT:
//   - Each cycle writes DEFAULT[idx] to table[idx], then idx++.
//   - After the last entry is written, moves to RUN; the init takes 2**ADDR_W cycles.
//   - DEFAULT[0..12] = F1,80,81,C8,82,26,D7,40,00,F5,80,4A,F0; all other entries are 00.
//   - With DATA_W>8 the defaults are sign-extended; with DATA_W<8 they are truncated.
//   - rd_en is ignored (rd_valid stays 0). wr_ready=0. busy=1.
// - RUN: busy=0, wr_ready=1.
//   - Write handshake: wr_valid&&wr_ready on edge N updates table[wr_addr] at that edge.
//   - Read: rd_en on edge N gives datOut and rd_valid=1 after edge N, i.e. 1-cycle latency.
//     - Indexed form: datOut = table[rd_in[ADDR_W-1:0]].
//     - Direct form: datOut = zero-extended rd_in[ADDR_W-1:0] (0..2**ADDR_W-1).
//   - No rd_en: rd_valid=0 and datOut holds its last value.
//   - Reads and writes may occur in the same cycle; reads always have full throughput.
//   - Same-cycle read and write to the same entry: read returns the OLD value; later reads see the new one.
//   - Back-to-back reads return one result per cycle, in order.
// - Out-of-range conditions do not exist: every wr_addr and rd_in value is valid.
// CONFIGURATION
// - Macro IMM_LUT_LOCK_EN adds input lock_req (1 bit), output locked (1 bit), output wr_err (1 bit).
//   - lock_req=1 in RUN moves the state to LOCKED next cycle; locked=1 while in LOCKED.
//   - lock_req is ignored in INIT.
//   - In LOCKED, wr_ready stays 1 but accepted writes are dropped.
//   - Each dropped write pulses wr_err for 1 cycle after the accepting edge.
//   - Reads behave exactly as in RUN. Only Reset leaves LOCKED.
//   - Reset values: locked=0, wr_err=0.
// - Without the macro: these ports and the LOCKED state are absent, and writes are always applied.
// TESTING
// - Reset held 2 cycles, then released:
//   - busy=1 and wr_ready=0 for exactly 16 cycles, then busy=0 and wr_ready=1.
//   - Indexed reads of entries 0..15 return F1,80,81,C8,82,26,D7,40,00,F5,80,4A,F0,00,00,00.
// - Direct reads rd_in=5'b00111, then 5'b01111 on consecutive cycles:
//   - rd_valid=1 on both following cycles with datOut=07, then 0F.
//   - rd_valid=0 afterwards and datOut stays 0F.
// - Write addr 3 := 5A, then indexed read 3 next cycle -> 5A.
// - Same-cycle write addr 1 := 33 and indexed read 1 -> 80; a read of 1 next cycle -> 33.
// - Reset asserted at init cycle 7, after entry 2 was overwritten:
//   - Init restarts with a full 16 cycles; entry 2 reads 81 again.
//   - A write presented during init is not accepted (wr_ready=0).
// - IMM_LUT_LOCK_EN:
//   - lock_req pulse, then write addr 0 := 11 -> wr_err pulses; entry 0 still reads F1.
//   - Reset -> locked=0 and writes apply again.

Source files
------------

// File: rtl/imm_lut_ctrl.sv
// Writable immediate lookup table: reloads defaults after reset, 1-cycle reads, valid/ready writes.
// Optional write lock enabled by macro IMM_LUT_LOCK_EN (adds lock_req, locked, wr_err).
module imm_lut_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   rd_in,
  output logic              rd_valid,
  output logic [DATA_W-1:0] datOut,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy
`ifdef IMM_LUT_LOCK_EN
  ,
  input  logic              lock_req,
  output logic              locked,
  output logic              wr_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef IMM_LUT_LOCK_EN
  typedef enum logic [1:0] {S_INIT, S_RUN, S_LOCKED} state_t;
`else
  typedef enum logic [1:0] {S_INIT, S_RUN} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              rd_valid_q, rd_valid_d;
`ifdef IMM_LUT_LOCK_EN
  logic              wr_err_q, wr_err_d;
`endif

  // Default immediates are 8-bit; sign-extend or truncate to DATA_W.
  function automatic logic [DATA_W-1:0] def_val(input logic [ADDR_W-1:0] i);
    logic [7:0]        b;
    logic [DATA_W-1:0] r;
    case (int'(i))
      0:       b = 8'hF1;
      1:       b = 8'h80;
      2:       b = 8'h81;
      3:       b = 8'hC8;
      4:       b = 8'h82;
      5:       b = 8'h26;
      6:       b = 8'hD7;
      7:       b = 8'h40;
      8:       b = 8'h00;
      9:       b = 8'hF5;
      10:      b = 8'h80;
      11:      b = 8'h4A;
      12:      b = 8'hF0;
      default: b = 8'h00;
    endcase
    for (int k = 0; k < DATA_W; k++) begin
      r[k] = (k < 8) ? b[3'(k)] : b[7];
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mem_d      = mem_q;
    dat_d      = dat_q;
    rd_valid_d = 1'b0;
    wr_ready   = 1'b0;
    busy       = 1'b0;
`ifdef IMM_LUT_LOCK_EN
    wr_err_d   = 1'b0;
`endif
    if (state_q == S_INIT) begin
      busy          = 1'b1;
      mem_d[idx_q]  = def_val(idx_q);
      idx_d         = idx_q + ADDR_W'(1);
      if (idx_q == LAST_IDX) begin
        state_d = S_RUN;
      end
    end else begin
      wr_ready = 1'b1;
      // Read samples mem_q, so a same-cycle write to the same entry returns the old value.
      if (rd_en) begin
        rd_valid_d = 1'b1;
        dat_d      = rd_in[ADDR_W] ? mem_q[rd_in[ADDR_W-1:0]] : DATA_W'(rd_in[ADDR_W-1:0]);
      end
`ifdef IMM_LUT_LOCK_EN
      if (wr_valid) begin
        if (state_q == S_LOCKED) begin
          wr_err_d = 1'b1;
        end else begin
          mem_d[wr_addr] = wr_data;
        end
      end
      if (state_q == S_RUN && lock_req) begin
        state_d = S_LOCKED;
      end
`else
      if (wr_valid) begin
        mem_d[wr_addr] = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_INIT;
      idx_q      <= '0;
      dat_q      <= '0;
      rd_valid_q <= 1'b0;
`ifdef IMM_LUT_LOCK_EN
      wr_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dat_q      <= dat_d;
      rd_valid_q <= rd_valid_d;
      mem_q      <= mem_d;
`ifdef IMM_LUT_LOCK_EN
      wr_err_q   <= wr_err_d;
`endif
    end
  end

  assign datOut   = dat_q;
  assign rd_valid = rd_valid_q;
`ifdef IMM_LUT_LOCK_EN
  assign wr_err   = wr_err_q;
  assign locked   = (state_q == S_LOCKED);
`endif

endmodule

// File: tb/tb_imm_lut_ctrl.sv
// Self-checking bench for imm_lut_ctrl: directed steps plus a randomized phase against a table model.
module tb_imm_lut_ctrl;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       rd_en;
  logic [4:0] rd_in;
  logic       rd_valid;
  logic [7:0] datOut;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
`ifdef IMM_LUT_LOCK_EN
  logic       lock_req;
  logic       locked;
  logic       wr_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] defaults [16] = '{8'hF1, 8'h80, 8'h81, 8'hC8, 8'h82, 8'h26, 8'hD7, 8'h40,
                                8'h00, 8'hF5, 8'h80, 8'h4A, 8'hF0, 8'h00, 8'h00, 8'h00};
  logic [7:0] model [16];
  logic [7:0] exp_dat;

  imm_lut_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .rd_en(rd_en), .rd_in(rd_in), .rd_valid(rd_valid),
    .datOut(datOut), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
`ifdef IMM_LUT_LOCK_EN
    , .lock_req(lock_req), .locked(locked), .wr_err(wr_err)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Waits out an init sequence, checking handshake outputs each cycle; returns busy-cycle count.
  task automatic run_init(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      chk("init_wr_ready", wr_ready, 0);
      chk("init_rd_valid", rd_valid, 0);
      cnt++;
      step();
    end
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp, input string tag);
    rd_en = 1'b1;
    rd_in = a;
    step();
    rd_en = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk(tag, datOut, exp);
  endtask

  initial begin
    int cnt;
    Reset = 1'b1; rd_en = 1'b0; rd_in = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef IMM_LUT_LOCK_EN
    lock_req = 1'b0;
`endif
    step();
    step();
    chk("rst_datOut", datOut, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
`ifdef IMM_LUT_LOCK_EN
    chk("rst_locked", locked, 0);
    chk("rst_wr_err", wr_err, 0);
`endif

    // Release reset with reads and a write pending; both must be ignored during init.
    Reset = 1'b0;
    rd_en = 1'b1; rd_in = 5'b10010;
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 8'hEE;
    run_init(cnt);
    rd_en = 1'b0; wr_valid = 1'b0;
    chk("init_len", cnt, 16);
    chk("run_busy", busy, 0);
    chk("run_wr_ready", wr_ready, 1);
    chk("run_rd_valid_first", rd_valid, 0);
    for (int i = 0; i < 16; i++) model[i] = defaults[i];

    // Back-to-back indexed reads of the whole table.
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      rd_in = {1'b1, 4'(i)};
      step();
      chk("idx_rd_vld", rd_valid, 1);
      chk($sformatf("idx_rd_%0d", i), datOut, model[i]);
    end
    rd_en = 1'b0;

    // Direct reads, then hold.
    rd_en = 1'b1; rd_in = 5'b00111;
    step();
    chk("dir7_vld", rd_valid, 1);
    chk("dir7", datOut, 8'h07);
    rd_in = 5'b01111;
    step();
    rd_en = 1'b0;
    chk("dir15_vld", rd_valid, 1);
    chk("dir15", datOut, 8'h0F);
    step();
    chk("hold_vld", rd_valid, 0);
    chk("hold_dat", datOut, 8'h0F);
    step();
    chk("hold_dat2", datOut, 8'h0F);

    // Write then read.
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    model[3] = 8'h5A;
    do_read(5'b10011, model[3], "wr3_rd");

    // Same-cycle write and read of one entry: old value first, then new.
    wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 8'h33;
    do_read(5'b10001, 8'h80, "same_cyc_old");
    wr_valid = 1'b0;
    model[1] = 8'h33;
    do_read(5'b10001, 8'h33, "same_cyc_new");

    // Randomized concurrent traffic.
    exp_dat = datOut;
    for (int n = 0; n < 300; n++) begin
      logic       exp_vld;
      rd_en    = ($urandom_range(0, 3) != 0);
      rd_in    = 5'($urandom);
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr  = 4'($urandom);
      wr_data  = 8'($urandom);
      exp_vld  = rd_en;
      if (rd_en) exp_dat = rd_in[4] ? model[rd_in[3:0]] : {4'h0, rd_in[3:0]};
      if (wr_valid) model[wr_addr] = wr_data;
      step();
      chk("rnd_vld", rd_valid, exp_vld);
      chk("rnd_dat", datOut, exp_dat);
      chk("rnd_wr_ready", wr_ready, 1);
    end
    rd_en = 1'b0; wr_valid = 1'b0;

    // Overwrite entry 2, reset, reset again at init cycle 7 with a write pending.
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 8'h99;
    step();
    wr_valid = 1'b0;
    do_read(5'b10010, 8'h99, "ovr2_rd");
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst2_datOut", datOut, 0);
    chk("rst2_rd_valid", rd_valid, 0);
    for (int i = 0; i < 7; i++) step();
    chk("mid_init_busy", busy, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
    rd_en = 1'b1; rd_in = 5'b10010;
    run_init(cnt);
    wr_valid = 1'b0; rd_en = 1'b0;
    chk("reinit_len", cnt, 16);
    for (int i = 0; i < 16; i++) model[i] = defaults[i];
    do_read(5'b10010, model[2], "reinit_rd2");
    do_read(5'b10001, model[1], "reinit_rd1");
    do_read(5'b10011, model[3], "reinit_rd3");

`ifdef IMM_LUT_LOCK_EN
    chk("lk_locked0", locked, 0);
    lock_req = 1'b1;
    step();
    lock_req = 1'b0;
    chk("lk_locked1", locked, 1);
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 8'h11;
    step();
    wr_valid = 1'b0;
    chk("lk_wr_err", wr_err, 1);
    chk("lk_wr_ready", wr_ready, 1);
    do_read(5'b10000, 8'hF1, "lk_rd0");
    chk("lk_wr_err_clr", wr_err, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("lk_rst_locked", locked, 0);
    run_init(cnt);
    chk("lk_reinit_len", cnt, 16);
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 8'h11;
    step();
    wr_valid = 1'b0;
    chk("lk_unlocked_err", wr_err, 0);
    do_read(5'b10000, 8'h11, "lk_unlocked_rd0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
